seg_capture: RTL
================

SEG_CAPTURE -- requirements
Module: seg_capture

Interface
REQ-001 Parameter STABLE_CYCLES, default 4: consecutive identical samples required to accept a digit.
REQ-002 Parameter TIMEOUT_CYCLES, default 65536: cycles without a completed frame before link_lost asserts.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 sm_wei  input  4  digit select from the display driver; active-low; bit0 = units, bit1 = tens; bits 3:2 ignored.
REQ-006 sm_duan  input  8  segment lines; active-low; bit7 = dp (ignored), bits 6:0 = g..a.
REQ-007 countdown_time  output  5  last accepted displayed value, 0..31.
REQ-008 frame_valid  output  1  one-cycle pulse when a frame completes and countdown_time updates.
REQ-009 changed  output  1  one-cycle pulse, coincident with frame_valid, when the new value differs from the previous one.
REQ-010 seg_err  output  1  one-cycle pulse on an undecodable pattern or an out-of-range value.
REQ-011 link_lost  output  1  level; no completed frame within TIMEOUT_CYCLES.

Function
REQ-012 sm_wei and sm_duan shall pass through a 2-flop synchronizer; all timing below is counted from synchronized samples.
REQ-013 Decode: active-low patterns C0,F9,A4,B0,99,92,82,F8,80,90 (dp masked to 1) shall map to 0..9; any other pattern shall be invalid.
REQ-014 Exception: FF (blank) on the tens digit shall decode as 0 (leading-zero blanking); on the units digit it shall be invalid.
REQ-015 FSM states: HUNT, SETTLE, LATCHED.
REQ-016 HUNT: stay while sm_wei[1:0] is not exactly one-hot-low (10 or 01); otherwise go to SETTLE, with the stability counter at 1.
REQ-017 SETTLE: when the {wei,duan} sample equals the previous one, increment the counter; otherwise restart at 1, or go to HUNT if the select is not one-hot-low.
REQ-018 SETTLE: when the counter reaches STABLE_CYCLES, latch the digit (units or tens per select), then go to LATCHED.
REQ-019 If the latched pattern is invalid, pulse seg_err and clear both digit-captured flags.
REQ-020 LATCHED: hold until {wei,duan} changes; then go to SETTLE if the select is one-hot-low, else to HUNT.
REQ-021 Frame completion: the cycle after both the units and tens captured flags are set, compute value = tens*10 + units using 7-bit arithmetic, then clear both flags.
REQ-022 If value <= 31: load countdown_time, pulse frame_valid, pulse changed if the value differs, reload the timeout counter, clear link_lost.
REQ-023 If value > 31: pulse seg_err; countdown_time, frame_valid and the timeout counter are untouched.
REQ-024 Re-latching a digit already captured in the current frame shall overwrite it; the newest value wins.
REQ-025 Timeout counter saturates; link_lost asserts on the cycle it reaches TIMEOUT_CYCLES and stays high until the next valid frame.
REQ-026 A simultaneous frame completion and timeout expiry: the frame wins and link_lost stays 0.

Reset
REQ-027 While rst = 1 at a clock edge, the following shall hold:
- FSM returns to HUNT.
- Synchronizers load 0xF / 0xFF (idle).
- Counters and captured flags clear.
- countdown_time = 0; frame_valid, changed and seg_err = 0; link_lost = 1.
REQ-028 Reset mid-frame shall discard partial digits; no output pulse shall occur in the cycle after reset is released.

Structure
REQ-029 Shared package: segment pattern constants (0..9, blank), FSM state encoding, and the 31 maximum value.
REQ-030 One sub-module, seg7_dec: combinational pattern -> 4-bit digit plus valid flag, with a tens-blank enable input.

Verification
REQ-031 Display 23 (tens A4, units B0), each digit held 8 cycles, alternating -> frame_valid pulses, countdown_time = 23, changed = 1 on the first frame and 0 on repeats.
REQ-032 Units digit held only 3 cycles (STABLE_CYCLES = 4) -> no latch, no frame_valid.
REQ-033 Tens FF, units 99 -> countdown_time = 4; then tens F9, units 99 -> countdown_time = 14 with changed pulse.
REQ-034 Units pattern 0x7F -> seg_err pulse; tens 0x99 plus units C0 (value 40) -> seg_err, countdown_time held.
REQ-035 No activity for 65536 cycles -> link_lost = 1; next valid frame -> link_lost = 0 on the frame_valid cycle.
REQ-036 rst asserted after tens latched, before units -> outputs at reset values; the next frame needs both digits again.

Source files
------------

// File: rtl/seg_capture_pkg.sv
// Shared definitions for the seven-segment countdown capture block:
// segment patterns, FSM encoding and the largest accepted value.
package seg_capture_pkg;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam logic [6:0] MAX_VALUE = 7'd31;

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_LATCHED = 2'd2
    } state_t;

endpackage

// File: rtl/seg_capture_dec.sv
// Combinational seven-segment decoder: active-low pattern to BCD digit.
// A blank pattern is accepted as 0 only when leading-zero blanking applies.
module seg7_dec
    import seg_capture_pkg::*;
(
    input  logic [7:0] i_pat,
    input  logic       i_blank_ok,
    output logic [3:0] o_digit,
    output logic       o_valid
);

    logic [7:0] w_pat;

    // The decimal point never carries digit information.
    assign w_pat = i_pat | 8'h80;

    always_comb begin
        o_digit = 4'd0;
        o_valid = 1'b1;
        unique case (w_pat)
            SEG_0:     o_digit = 4'd0;
            SEG_1:     o_digit = 4'd1;
            SEG_2:     o_digit = 4'd2;
            SEG_3:     o_digit = 4'd3;
            SEG_4:     o_digit = 4'd4;
            SEG_5:     o_digit = 4'd5;
            SEG_6:     o_digit = 4'd6;
            SEG_7:     o_digit = 4'd7;
            SEG_8:     o_digit = 4'd8;
            SEG_9:     o_digit = 4'd9;
            SEG_BLANK: o_valid = i_blank_ok;
            default:   o_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_capture.sv
// Snoops a two-digit multiplexed seven-segment display and recovers the
// shown countdown value, with glitch filtering and a loss-of-link monitor.
module seg_capture
    import seg_capture_pkg::*;
#(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sm_wei,
    input  logic [7:0] sm_duan,
    output logic [4:0] countdown_time,
    output logic       frame_valid,
    output logic       changed,
    output logic       seg_err,
    output logic       link_lost
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] C_STABLE = CW'(STABLE_CYCLES);
    localparam logic [TW-1:0] C_TMO    = TW'(TIMEOUT_CYCLES);

    logic [3:0]    r_wei_s1, r_wei_s2;
    logic [7:0]    r_duan_s1, r_duan_s2;
    logic [9:0]    r_prev;
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_units, r_tens;
    logic          r_units_ok, r_tens_ok;
    logic [4:0]    r_time;
    logic          r_fv, r_ch, r_err, r_ll;
    logic [TW-1:0] r_tmo;

    logic [9:0]    w_cur;
    logic          w_sel_ok, w_same, w_is_tens;
    logic [CW-1:0] w_cnt_nx;
    logic [3:0]    w_dig;
    logic          w_dig_ok;
    logic [6:0]    w_value;
    logic          w_frame, w_in_range, w_frame_ok;
    logic [1:0]    w_unused_wei;

    assign w_unused_wei = r_wei_s2[3:2];
    assign w_cur      = {r_wei_s2[1:0], r_duan_s2};
    assign w_sel_ok   = (w_cur[9:8] == 2'b10) || (w_cur[9:8] == 2'b01);
    assign w_is_tens  = (w_cur[9:8] == 2'b01);
    assign w_same     = (w_cur == r_prev);
    assign w_cnt_nx   = r_cnt + CW'(1);
    assign w_value    = {3'b000, r_tens} * 7'd10 + {3'b000, r_units};
    assign w_frame    = r_units_ok & r_tens_ok;
    assign w_in_range = (w_value <= MAX_VALUE);
    assign w_frame_ok = w_frame & w_in_range;

    seg7_dec u_dec (
        .i_pat      (r_duan_s2),
        .i_blank_ok (w_is_tens),
        .o_digit    (w_dig),
        .o_valid    (w_dig_ok)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wei_s1  <= 4'hF;
            r_wei_s2  <= 4'hF;
            r_duan_s1 <= 8'hFF;
            r_duan_s2 <= 8'hFF;
        end else begin
            r_wei_s1  <= sm_wei;
            r_wei_s2  <= r_wei_s1;
            r_duan_s1 <= sm_duan;
            r_duan_s2 <= r_duan_s1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_HUNT;
            r_prev     <= {2'b11, 8'hFF};
            r_cnt      <= '0;
            r_units    <= 4'd0;
            r_tens     <= 4'd0;
            r_units_ok <= 1'b0;
            r_tens_ok  <= 1'b0;
            r_time     <= 5'd0;
            r_fv       <= 1'b0;
            r_ch       <= 1'b0;
            r_err      <= 1'b0;
            r_ll       <= 1'b1;
            r_tmo      <= '0;
        end else begin
            r_prev <= w_cur;
            r_fv   <= 1'b0;
            r_ch   <= 1'b0;
            r_err  <= 1'b0;

            if (w_frame) begin
                r_units_ok <= 1'b0;
                r_tens_ok  <= 1'b0;
                if (w_in_range) begin
                    r_time <= w_value[4:0];
                    r_fv   <= 1'b1;
                    r_ch   <= (w_value[4:0] != r_time);
                end else begin
                    r_err <= 1'b1;
                end
            end

            unique case (r_state)
                ST_HUNT: begin
                    if (w_sel_ok) begin
                        r_state <= ST_SETTLE;
                        r_cnt   <= CW'(1);
                    end
                end
                ST_SETTLE: begin
                    if (!w_same) begin
                        r_cnt <= CW'(1);
                        if (!w_sel_ok)
                            r_state <= ST_HUNT;
                    end else if (w_cnt_nx == C_STABLE) begin
                        r_state <= ST_LATCHED;
                        r_cnt   <= w_cnt_nx;
                        // A corrupt digit poisons the whole frame.
                        if (!w_dig_ok) begin
                            r_err      <= 1'b1;
                            r_units_ok <= 1'b0;
                            r_tens_ok  <= 1'b0;
                        end else if (w_is_tens) begin
                            r_tens    <= w_dig;
                            r_tens_ok <= 1'b1;
                        end else begin
                            r_units    <= w_dig;
                            r_units_ok <= 1'b1;
                        end
                    end else begin
                        r_cnt <= w_cnt_nx;
                    end
                end
                ST_LATCHED: begin
                    if (!w_same) begin
                        r_cnt   <= CW'(1);
                        r_state <= w_sel_ok ? ST_SETTLE : ST_HUNT;
                    end
                end
                default: r_state <= ST_HUNT;
            endcase

            // A good frame takes priority over an expiring timeout.
            if (w_frame_ok) begin
                r_tmo <= '0;
                r_ll  <= 1'b0;
            end else if (r_tmo != C_TMO) begin
                r_tmo <= r_tmo + TW'(1);
                if (r_tmo + TW'(1) == C_TMO)
                    r_ll <= 1'b1;
            end
        end
    end

    assign countdown_time = r_time;
    assign frame_valid    = r_fv;
    assign changed        = r_ch;
    assign seg_err        = r_err;
    assign link_lost      = r_ll;

endmodule
